// File: rtl/fetch_stage_pkg.sv
// Shared constants for the P5 fetch stage: next-PC source encodings and the
// instruction-memory window used by the fetch address check.
package fetch_stage_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_WORDS = 32'd4096;
  localparam logic [31:0] IM_LAST  = IM_BASE + (IM_WORDS << 2) - 32'd4;

  // True when a fetch at addr must raise an address-error exception.
  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Next-PC selection. Branch and jump targets are relative to the
// control-transfer instruction sitting in D, not to the PC being fetched.
module f_npc
  import fetch_stage_pkg::*;
(
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16_d,
  input  logic [25:0] idx26_d,
  input  logic [31:0] rs_d,
  output logic [31:0] npc
);

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign seq_pc    = pc_f + 32'd4;
  assign br_target = pc_d + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
  assign j_target  = {pc_d[31:28], idx26_d, 2'b00};

  always_comb begin
    npc = seq_pc;
    case (npc_sel)
      NPC_SEQ: npc = seq_pc;
      NPC_BR:  npc = br_taken ? br_target : seq_pc;
      NPC_J:   npc = j_target;
      NPC_JR:  npc = rs_d;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, fetch address check and the F/D
// pipeline register. The delay-slot instruction is never squashed.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        STALL,
  input  logic [1:0]  NPC_SEL,
  input  logic        BR_TAKEN,
  input  logic [15:0] IMM16_D,
  input  logic [25:0] IDX26_D,
  input  logic [31:0] RS_D,
  output logic [31:0] PC_F,
  input  logic [31:0] INSTR_F,
  output logic [31:0] INSTR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        ADEL_D
);

  logic [31:0] npc;
  logic        fetch_bad;

  f_npc u_npc (
    .npc_sel  (NPC_SEL),
    .br_taken (BR_TAKEN),
    .pc_f     (PC_F),
    .pc_d     (PC_D),
    .imm16_d  (IMM16_D),
    .idx26_d  (IDX26_D),
    .rs_d     (RS_D),
    .npc      (npc)
  );

  assign fetch_bad = fetch_addr_bad(PC_F);

  // Flow control: STALL=1 freezes PC and F/D together, so D (and therefore
  // NPC_SEL) is re-presented on the first unstalled cycle; STALL=0 advances
  // both by one entry per edge. Reset wins over STALL.
  always_ff @(posedge clk) begin
    if (!reset) begin
      PC_F    <= PC_RESET;
      INSTR_D <= 32'd0;
      PC_D    <= PC_RESET;
      PC8_D   <= PC_RESET + 32'd8;
      ADEL_D  <= 1'b0;
    end else if (!STALL) begin
      PC_F    <= npc;
      INSTR_D <= fetch_bad ? 32'd0 : INSTR_F;
      PC_D    <= PC_F;
      PC8_D   <= PC_F + 32'd8;
      ADEL_D  <= fetch_bad;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each driven cycle pushes the expected
// post-edge state; a monitor pops and compares it after every edge.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [15:0] imm16_d;
  logic [25:0] idx26_d;
  logic [31:0] rs_d;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        adel_d;

  localparam int W = 129;
  logic [W-1:0] exp_q[$];

  int total = 0;
  int bad = 0;

  fetch_stage dut (
    .clk      (clk),
    .reset    (reset),
    .STALL    (stall),
    .NPC_SEL  (npc_sel),
    .BR_TAKEN (br_taken),
    .IMM16_D  (imm16_d),
    .IDX26_D  (idx26_d),
    .RS_D     (rs_d),
    .PC_F     (pc_f),
    .INSTR_F  (instr_f),
    .INSTR_D  (instr_d),
    .PC_D     (pc_d),
    .PC8_D    (pc8_d),
    .ADEL_D   (adel_d)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Model instruction memory: every word is distinct and nonzero.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  assign instr_f = im_word(pc_f);

  // Driver: apply current inputs, push the expected state after the edge.
  task automatic tick(input logic [31:0] e_pc_f, input logic [31:0] e_pc_d,
                      input logic e_nop, input logic e_adel);
    logic [31:0] e_instr;
    e_instr = e_nop ? 32'd0 : im_word(e_pc_d);
    exp_q.push_back({e_pc_f, e_instr, e_pc_d, e_pc_d + 32'd8, e_adel});
    @(posedge clk);
    #3;
  endtask

  task automatic seq(input logic [31:0] e_pc_f, input logic [31:0] e_pc_d);
    npc_sel = 2'b00;
    tick(e_pc_f, e_pc_d, 1'b0, 1'b0);
  endtask

  task automatic jr(input logic [31:0] target, input logic [31:0] e_pc_d,
                    input logic e_nop, input logic e_adel);
    npc_sel = 2'b11;
    rs_d    = target;
    tick(target, e_pc_d, e_nop, e_adel);
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] exp;
    logic [W-1:0] got;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        got = {pc_f, instr_d, pc_d, pc8_d, adel_d};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL entry%0d: got pc_f=%h instr_d=%h pc_d=%h pc8_d=%h adel_d=%b, want pc_f=%h instr_d=%h pc_d=%h pc8_d=%h adel_d=%b",
                   total, got[128:97], got[96:65], got[64:33], got[32:1], got[0],
                   exp[128:97], exp[96:65], exp[64:33], exp[32:1], exp[0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset    = 1'b0;
    stall    = 1'b0;
    npc_sel  = 2'b00;
    br_taken = 1'b0;
    imm16_d  = 16'h0000;
    idx26_d  = 26'h0;
    rs_d     = 32'h0;

    tick(32'h3000, 32'h3000, 1'b1, 1'b0);
    tick(32'h3000, 32'h3000, 1'b1, 1'b0);
    reset = 1'b1;
    seq(32'h3004, 32'h3000);
    seq(32'h3008, 32'h3004);
    seq(32'h300C, 32'h3008);
    seq(32'h3010, 32'h300C);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) seq(32'h3010, 32'h300C);
    stall = 1'b0;
    seq(32'h3014, 32'h3010);
    seq(32'h3018, 32'h3014);
    seq(32'h301C, 32'h3018);
    seq(32'h3020, 32'h301C);
    seq(32'h3024, 32'h3020);

    // Taken branch back by 4 words from PC_D=0x3020.
    npc_sel  = 2'b01;
    br_taken = 1'b1;
    imm16_d  = 16'hFFFC;
    tick(32'h3014, 32'h3024, 1'b0, 1'b0);
    seq(32'h3018, 32'h3014);
    seq(32'h301C, 32'h3018);
    seq(32'h3020, 32'h301C);
    seq(32'h3024, 32'h3020);
    npc_sel  = 2'b01;
    br_taken = 1'b0;
    tick(32'h3028, 32'h3024, 1'b0, 1'b0);

    for (int a = 32'h302C; a <= 32'h3044; a += 4) seq(a, a - 4);
    npc_sel = 2'b10;
    idx26_d = 26'h0000C10;
    tick(32'h3040, 32'h3044, 1'b0, 1'b0);
    jr(32'h3100, 32'h3040, 1'b0, 1'b0);
    seq(32'h3104, 32'h3100);

    // Misaligned, above-window, last-legal and below-window fetches.
    jr(32'h3102, 32'h3104, 1'b0, 1'b0);
    npc_sel = 2'b00;
    tick(32'h3106, 32'h3102, 1'b1, 1'b1);
    jr(32'h7000, 32'h3106, 1'b1, 1'b1);
    npc_sel = 2'b00;
    tick(32'h7004, 32'h7000, 1'b1, 1'b1);
    jr(32'h6FFC, 32'h7004, 1'b1, 1'b1);
    seq(32'h7000, 32'h6FFC);
    npc_sel = 2'b00;
    tick(32'h7004, 32'h7000, 1'b1, 1'b1);
    jr(32'h2FFC, 32'h7004, 1'b1, 1'b1);
    npc_sel = 2'b00;
    tick(32'h3000, 32'h2FFC, 1'b1, 1'b1);
    seq(32'h3004, 32'h3000);

    // Reset asserted while stalled.
    seq(32'h3008, 32'h3004);
    stall = 1'b1;
    reset = 1'b0;
    tick(32'h3000, 32'h3000, 1'b1, 1'b0);
    stall = 1'b0;
    reset = 1'b1;
    seq(32'h3004, 32'h3000);

    repeat (2) @(posedge clk);
    #4;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the P5 pipelined MIPS core, directly upstream of the instruction memory.
- Owns the PC register and next-PC selection, including the branch/jump delay slot, and drives PC_F into the instruction memory.
- Captures the returned INSTR_F into the F/D pipeline register that feeds decode.
- Flags fetches outside the instruction-memory window or not word-aligned.

Parameters:
PC_RESET, 32'h0000_3000, PC value after reset
IM_BASE, 32'h0000_3000, first byte address of instruction memory
IM_WORDS, 4096, instruction-memory depth in 32-bit words

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
STALL  in  1  hazard-unit freeze of PC and F/D register
NPC_SEL  in  2  next-PC source from decode: 00 seq, 01 branch, 10 j/jal, 11 jr
BR_TAKEN  in  1  branch condition result from decode (used only when NPC_SEL=01)
IMM16_D  in  16  branch offset of the instruction in D
IDX26_D  in  26  jump index of the instruction in D
RS_D  in  32  forwarded rs value for jr/jalr
PC_F  out  32  current fetch address, to instruction memory
INSTR_F  in  32  instruction word returned combinationally by instruction memory
INSTR_D  out  32  F/D register: instruction
PC_D  out  32  F/D register: PC of INSTR_D
PC8_D  out  32  F/D register: PC_D+8 (link address)
ADEL_D  out  1  F/D register: fetch address error for INSTR_D

Behaviour:
- All state updates on the posedge of clk. While reset=0 at an edge:
  - PC_F <= PC_RESET
  - INSTR_D <= 0 (nop)
  - PC_D <= PC_RESET
  - PC8_D <= PC_RESET+8
  - ADEL_D <= 0
- Reset overrides STALL and all other inputs.
- NPC (combinational, 32-bit arithmetic, wraps modulo 2^32):
  - 00: PC_F+4
  - 01: BR_TAKEN ? PC_D+4+(sext(IMM16_D)<<2) : PC_F+4
  - 10: {PC_D[31:28], IDX26_D, 2'b00}
  - 11: RS_D, used unmodified
- Delay slot: when the control-transfer instruction sits in D, the delay-slot instruction is in F and is always captured into D. There is no flush port; the delay slot is never squashed.
- STALL=1: PC_F, INSTR_D, PC_D, PC8_D and ADEL_D all hold. Because D is frozen, NPC_SEL is re-evaluated on the first unstalled cycle.
- STALL=0: PC_F <= NPC; INSTR_D/PC_D/PC8_D/ADEL_D load from the F side. Latency from PC_F to INSTR_D is exactly one edge.
- Fetch error: bad = PC_F[1:0]!=0 OR PC_F<IM_BASE OR PC_F>IM_BASE+4*IM_WORDS-4 (0x0000_6FFC at defaults).
  - When bad, the F/D register loads INSTR_D=0 and ADEL_D=1, with PC_D/PC8_D still recording the faulting PC.
  - The PC continues to advance per NPC; the exception flag is consumed downstream.
- Boundary at PC_F=0x0000_6FFC: legal. With NPC_SEL=00 the next PC is 0x0000_7000, which is flagged at its fetch.
- No combinational path from INSTR_F to PC_F.
- PC_F is a direct register output, so instruction-memory address timing depends only on the PC register.

Decomposition:
- Shared package:
  - NPC_SEL encodings (NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11)
  - PC_RESET, IM_BASE, IM_WORDS
- One combinational sub-module, f_npc, computes NPC from NPC_SEL, BR_TAKEN, PC_F, PC_D, IMM16_D, IDX26_D and RS_D.
- fetch_stage instantiates f_npc and contains the PC register, the address check and the F/D register.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release with STALL=0, NPC_SEL=00 and a model IM loaded.
  - Required: PC_F=0x3000, INSTR_D=0, PC_D=0x3000, PC8_D=0x3008 during reset.
  - Required after release: PC_F steps 0x3004, 0x3008, ...
  - Required: INSTR_D equals mem[0] one edge after PC_F=0x3000.
- Stall: STALL=1 for 3 cycles at PC_F=0x3010.
  - Required: PC_F stays 0x3010; INSTR_D/PC_D stay frozen at the PC_D=0x300C entry.
  - Required: sequential fetch resumes at 0x3014.
- Branch with PC_D=0x3020, NPC_SEL=01, IMM16_D=16'hFFFC:
  - BR_TAKEN=1: delay slot 0x3024 enters D, then PC_F=0x3014.
  - BR_TAKEN=0: PC_F=0x3028.
- Jumps:
  - j with PC_D=0x3040, IDX26_D=26'h0000C10: next PC_F=0x3040.
  - jr with RS_D=0x0000_3100: next PC_F=0x3100.
  - In both cases the delay slot reaches D.
- Fetch error: jr to RS_D=0x0000_3102, then jr to 0x0000_7000.
  - Required for each: INSTR_D=0, ADEL_D=1, PC_D equal to the faulting address.
  - Required: a fetch at 0x6FFC gives ADEL_D=0.
- Reset during stall: STALL=1 and reset=0 in the same cycle.
  - Required: all outputs return to their reset values at that edge.
